mux_rr_nx1: RTL and testbench

- Parametrised N-to-1 round-robin multiplexer that merges several valid-qualified lane streams into one output stream. It is the successor to the 2x1 8-bit lane mux in the PHY.
- Each input channel has its own small FIFO, so short bursts are absorbed.
- Two selection modes: strict time-slot rotation, or work-conserving (skips empty channels).
- Single-edge design, posedge only.

---
 rtl/mux_rr_nx1.sv | 122 ++++++++++++
 tb/tb_mux_rr_nx1.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nx1.sv
// N-to-1 round-robin lane merger with a small FIFO per input channel.
// SKIP_EMPTY=0 gives fixed time slots; SKIP_EMPTY=1 skips channels with nothing queued.
module mux_rr_nx1 #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int SKIP_EMPTY = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_full,
    output logic [NUM_CH-1:0]          ovf_err,
    output logic [DATA_W-1:0]          data_out,
    output logic                       outValid,
    output logic [$clog2(NUM_CH)-1:0]  out_ch
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    logic [DATA_W-1:0] mem_q    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [NUM_CH-1:0] push, pop;
    logic [NUM_CH-1:0] full_q, full_d, ovf_q, ovf_d;
    logic [CH_W-1:0]   ptr_q, ptr_d, sel, idx;
    logic              found;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic [CH_W-1:0]   ch_q, ch_d;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        return (c == LAST_CH) ? '0 : c + CH_W'(1);
    endfunction

    // Channel selection: fixed slot, or first non-empty channel at/after ptr.
    always_comb begin
        sel   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        ptr_d = next_ch(ptr_q);
        if (SKIP_EMPTY == 0) begin
            found = (cnt_q[ptr_q] != '0);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && (cnt_q[idx] != '0)) begin
                    found = 1'b1;
                    sel   = idx;
                end
                idx = next_ch(idx);
            end
            ptr_d = found ? next_ch(sel) : ptr_q;
        end
    end

    // Fullness is judged on the pre-edge count, so a same-cycle pop never makes room.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            push[c]   = in_valid[c] && (cnt_q[c] != FULL_CNT);
            pop[c]    = found && (sel == CH_W'(c));
            cnt_d[c]  = cnt_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
            full_d[c] = (cnt_d[c] == FULL_CNT);
            ovf_d[c]  = ovf_q[c] | (in_valid[c] && (cnt_q[c] == FULL_CNT));
        end
    end

    always_comb begin
        vld_d  = found;
        data_d = found ? mem_q[sel][rd_ptr_q[sel]] : data_q;
        ch_d   = found ? sel : ch_q;
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            full_q <= '0;
            ovf_q  <= '0;
            ptr_q  <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
            ch_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PTR_W'(1);
                if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(1);
                cnt_q[c] <= cnt_d[c];
            end
            full_q <= full_d;
            ovf_q  <= ovf_d;
            ptr_q  <= ptr_d;
            data_q <= data_d;
            vld_q  <= vld_d;
            ch_q   <= ch_d;
        end
    end

    assign in_full  = full_q;
    assign ovf_err  = ovf_q;
    assign data_out = data_q;
    assign outValid = vld_q;
    assign out_ch   = ch_q;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Directed bench for mux_rr_nx1: one strict-rotation and one work-conserving
// instance share the same input stimulus.
module tb_mux_rr_nx1;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int DEP = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NCH*DW-1:0] in_data = '0;
    logic [NCH-1:0]    in_valid = '0;

    logic [NCH-1:0] s_full, s_ovf, w_full, w_ovf;
    logic [DW-1:0]  s_data, w_data;
    logic           s_vld, w_vld;
    logic [1:0]     s_ch, w_ch;

    int n_cmp = 0;
    int n_err = 0;

    mux_rr_nx1 #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .SKIP_EMPTY(0)) dut_s (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_full(s_full), .ovf_err(s_ovf), .data_out(s_data), .outValid(s_vld), .out_ch(s_ch)
    );

    mux_rr_nx1 #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .SKIP_EMPTY(1)) dut_w (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_full(w_full), .ovf_err(w_ovf), .data_out(w_data), .outValid(w_vld), .out_ch(w_ch)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1ns after a posedge with reset just released; next edge is the first active one.
    task automatic do_reset;
        in_valid = '0;
        in_data  = '0;
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++; if (s_vld !== 1'b0)   begin n_err++; $display("FAIL rst_s_vld: got %0b want 0", s_vld); end
        n_cmp++; if (s_data !== 8'h00) begin n_err++; $display("FAIL rst_s_data: got %h want 00", s_data); end
        n_cmp++; if (s_ch !== 2'd0)    begin n_err++; $display("FAIL rst_s_ch: got %0d want 0", s_ch); end
        n_cmp++; if (s_full !== 4'h0)  begin n_err++; $display("FAIL rst_s_full: got %b want 0000", s_full); end
        n_cmp++; if (s_ovf !== 4'h0)   begin n_err++; $display("FAIL rst_s_ovf: got %b want 0000", s_ovf); end
        n_cmp++; if (w_vld !== 1'b0)   begin n_err++; $display("FAIL rst_w_vld: got %0b want 0", w_vld); end
        step;
        n_cmp++; if (s_vld !== 1'b0)   begin n_err++; $display("FAIL rst_idle_vld: got %0b want 0", s_vld); end
    endtask

    task automatic fill_pattern;
        do_reset;
        step; step; step;
        in_data  = {8'h40, 8'h30, 8'h00, 8'h10};
        in_valid = 4'b1101;
        step;
        in_valid = '0;
    endtask

    task automatic test_strict_rotation;
        fill_pattern;
        n_cmp++; if (s_vld !== 1'b0) begin n_err++; $display("FAIL rot_e4_vld: got %0b want 0", s_vld); end
        step;
        n_cmp++; if ({s_vld, s_data, s_ch} !== {1'b1, 8'h10, 2'd0}) begin n_err++; $display("FAIL rot_e5: got v%0b d%h c%0d want v1 d10 c0", s_vld, s_data, s_ch); end
        step;
        n_cmp++; if ({s_vld, s_data, s_ch} !== {1'b0, 8'h10, 2'd0}) begin n_err++; $display("FAIL rot_e6: got v%0b d%h c%0d want v0 d10 c0", s_vld, s_data, s_ch); end
        step;
        n_cmp++; if ({s_vld, s_data, s_ch} !== {1'b1, 8'h30, 2'd2}) begin n_err++; $display("FAIL rot_e7: got v%0b d%h c%0d want v1 d30 c2", s_vld, s_data, s_ch); end
        step;
        n_cmp++; if ({s_vld, s_data, s_ch} !== {1'b1, 8'h40, 2'd3}) begin n_err++; $display("FAIL rot_e8: got v%0b d%h c%0d want v1 d40 c3", s_vld, s_data, s_ch); end
    endtask

    task automatic test_work_conserving;
        fill_pattern;
        step;
        n_cmp++; if ({w_vld, w_data, w_ch} !== {1'b1, 8'h10, 2'd0}) begin n_err++; $display("FAIL wc_1: got v%0b d%h c%0d want v1 d10 c0", w_vld, w_data, w_ch); end
        step;
        n_cmp++; if ({w_vld, w_data, w_ch} !== {1'b1, 8'h30, 2'd2}) begin n_err++; $display("FAIL wc_2: got v%0b d%h c%0d want v1 d30 c2", w_vld, w_data, w_ch); end
        step;
        n_cmp++; if ({w_vld, w_data, w_ch} !== {1'b1, 8'h40, 2'd3}) begin n_err++; $display("FAIL wc_3: got v%0b d%h c%0d want v1 d40 c3", w_vld, w_data, w_ch); end
        step;
        n_cmp++; if ({w_vld, w_data, w_ch} !== {1'b0, 8'h40, 2'd3}) begin n_err++; $display("FAIL wc_4: got v%0b d%h c%0d want v0 d40 c3", w_vld, w_data, w_ch); end
    endtask

    task automatic test_overflow;
        logic [7:0] word;
        do_reset;
        step;
        for (int k = 0; k < 4; k++) begin
            word = 8'hB1 + 8'(k);
            in_data = {8'h00, 8'h00, word, 8'h00};
            in_valid = 4'b0010;
            step;
        end
        n_cmp++; if (s_full[1] !== 1'b1) begin n_err++; $display("FAIL ovf_full_after4: got %0b want 1", s_full[1]); end
        n_cmp++; if (s_ovf !== 4'b0000)  begin n_err++; $display("FAIL ovf_clear_after4: got %b want 0000", s_ovf); end
        in_data = {8'h00, 8'h00, 8'hB5, 8'h00};
        step;
        in_valid = '0;
        n_cmp++; if (s_ovf !== 4'b0010)  begin n_err++; $display("FAIL ovf_set: got %b want 0010", s_ovf); end
        n_cmp++; if ({s_vld, s_data, s_ch} !== {1'b1, 8'hB1, 2'd1}) begin n_err++; $display("FAIL ovf_word1: got v%0b d%h c%0d want v1 dB1 c1", s_vld, s_data, s_ch); end
        n_cmp++; if (s_full[1] !== 1'b0) begin n_err++; $display("FAIL ovf_full_after_pop: got %0b want 0", s_full[1]); end
        for (int k = 1; k < 4; k++) begin
            word = 8'hB1 + 8'(k);
            step; step; step; step;
            n_cmp++; if ({s_vld, s_data, s_ch} !== {1'b1, word, 2'd1}) begin n_err++; $display("FAIL ovf_word%0d: got v%0b d%h c%0d want v1 d%h c1", k + 1, s_vld, s_data, s_ch, word); end
        end
        n_cmp++; if (s_ovf !== 4'b0010) begin n_err++; $display("FAIL ovf_sticky: got %b want 0010", s_ovf); end
    endtask

    task automatic test_slot_collision;
        do_reset;
        in_data  = {8'h00, 8'h00, 8'h00, 8'h55};
        in_valid = 4'b0001;
        step;
        in_valid = '0;
        n_cmp++; if (s_vld !== 1'b0) begin n_err++; $display("FAIL coll_same_slot: got %0b want 0", s_vld); end
        for (int k = 0; k < 3; k++) begin
            step;
            n_cmp++; if (s_vld !== 1'b0) begin n_err++; $display("FAIL coll_gap%0d: got %0b want 0", k, s_vld); end
        end
        step;
        n_cmp++; if ({s_vld, s_data, s_ch} !== {1'b1, 8'h55, 2'd0}) begin n_err++; $display("FAIL coll_late: got v%0b d%h c%0d want v1 d55 c0", s_vld, s_data, s_ch); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_d;
        logic [1:0] exp_c;
        do_reset;
        step; step; step;
        for (int k = 0; k <= 16; k++) begin
            if ((k % 4 == 0) && (k < 16)) begin
                for (int c = 0; c < NCH; c++) in_data[c*DW +: DW] = 8'h80 + 8'((k / 4) * 16 + c);
                in_valid = 4'b1111;
            end else begin
                in_valid = '0;
            end
            step;
            if (k >= 1) begin
                exp_c = 2'((k - 1) % 4);
                exp_d = 8'h80 + 8'(((k - 1) / 4) * 16 + ((k - 1) % 4));
                n_cmp++; if ({s_vld, s_data, s_ch} !== {1'b1, exp_d, exp_c}) begin n_err++; $display("FAIL stream_%0d: got v%0b d%h c%0d want v1 d%h c%0d", k - 1, s_vld, s_data, s_ch, exp_d, exp_c); end
            end
        end
        n_cmp++; if (s_ovf !== 4'b0000) begin n_err++; $display("FAIL stream_ovf: got %b want 0000", s_ovf); end
    endtask

    task automatic test_reset_midstream;
        do_reset;
        in_data  = {8'h00, 8'h00, 8'hA1, 8'h00};
        in_valid = 4'b0010;
        step;
        in_data  = {8'h00, 8'h00, 8'hA2, 8'h00};
        step;
        in_valid = '0;
        n_cmp++; if ({s_vld, s_data, s_ch} !== {1'b1, 8'hA1, 2'd1}) begin n_err++; $display("FAIL mid_pre: got v%0b d%h c%0d want v1 dA1 c1", s_vld, s_data, s_ch); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({s_vld, s_data, s_ch} !== {1'b0, 8'h00, 2'd0}) begin n_err++; $display("FAIL mid_async_s: got v%0b d%h c%0d want v0 d00 c0", s_vld, s_data, s_ch); end
        n_cmp++; if ({w_vld, w_data, w_ch} !== {1'b0, 8'h00, 2'd0}) begin n_err++; $display("FAIL mid_async_w: got v%0b d%h c%0d want v0 d00 c0", w_vld, w_data, w_ch); end
        @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step;
            n_cmp++; if ({s_vld, w_vld} !== 2'b00) begin n_err++; $display("FAIL mid_flushed%0d: got s%0b w%0b want s0 w0", k, s_vld, w_vld); end
        end
        in_data  = {8'h00, 8'h77, 8'h00, 8'h00};
        in_valid = 4'b0100;
        step;
        in_valid = '0;
        n_cmp++; if (s_vld !== 1'b0) begin n_err++; $display("FAIL mid_new_latency: got %0b want 0", s_vld); end
        step;
        n_cmp++; if ({s_vld, s_data, s_ch} !== {1'b1, 8'h77, 2'd2}) begin n_err++; $display("FAIL mid_new_s: got v%0b d%h c%0d want v1 d77 c2", s_vld, s_data, s_ch); end
        n_cmp++; if ({w_vld, w_data, w_ch} !== {1'b1, 8'h77, 2'd2}) begin n_err++; $display("FAIL mid_new_w: got v%0b d%h c%0d want v1 d77 c2", w_vld, w_data, w_ch); end
    endtask

    initial begin
        test_reset;
        test_strict_rotation;
        test_work_conserving;
        test_overflow;
        test_slot_collision;
        test_back_to_back;
        test_reset_midstream;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
